// File: rtl/fsm_window_packer.sv
// fsm_window_packer: packs window-end z results LSB-first into words, queued to a valid/ready port.
// Ports: clk; reset (async, active-low); win_end/z window result strobe; flush pushes partial word;
//        m_valid/m_ready/m_data/m_len output stream; hit_count saturating z=1 count;
//        overflow sticky drop flag; fifo_level occupied FIFO entries.
module fsm_window_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          win_end,
    input  logic                          z,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WORD_W-1:0]             m_data,
    output logic [$clog2(WORD_W):0]       m_len,
    output logic [CNT_W-1:0]              hit_count,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int IDX_W = $clog2(WORD_W) + 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic ST_EMPTY   = 1'b0;
    localparam logic ST_FILLING = 1'b1;

    logic              state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d, word_cap;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_cap;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic              ovf_q, ovf_d;
    logic              enq, deq, full, push;
    logic [WORD_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [IDX_W-1:0]  mem_len_q  [FIFO_DEPTH];

    always_comb begin
        word_cap = word_q;
        if (win_end) word_cap[idx_q[IDX_W-2:0]] = z;
        idx_cap  = idx_q + IDX_W'(win_end);
        // A completing capture wins over flush, so flush never adds a second (empty) word.
        enq      = (idx_cap == IDX_W'(WORD_W)) || (flush && (state_q == ST_FILLING || win_end));
        full     = level_q == LVL_W'(FIFO_DEPTH);
        deq      = m_valid && m_ready;
        push     = enq && (!full || deq);
        word_d   = enq ? '0 : word_cap;
        idx_d    = enq ? '0 : idx_cap;
        state_d  = (idx_d != '0) ? ST_FILLING : ST_EMPTY;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(deq);
        hit_d    = (win_end && z && hit_q != '1) ? hit_q + CNT_W'(1) : hit_q;
        ovf_d    = ovf_q | (enq && full && !deq);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_EMPTY;
            word_q   <= '0;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hit_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hit_q    <= hit_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the level counter alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= word_cap;
            mem_len_q[wr_ptr_q]  <= idx_cap;
        end
    end

    assign m_valid    = level_q != '0;
    assign m_data     = m_valid ? mem_data_q[rd_ptr_q] : '0;
    assign m_len      = m_valid ? mem_len_q[rd_ptr_q] : '0;
    assign hit_count  = hit_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_fsm_window_packer.sv
// tb_fsm_window_packer: directed table and sequence checks for fsm_window_packer.
module tb_fsm_window_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        win_end = 1'b0, z = 1'b0, flush = 1'b0, m_ready = 1'b0;
    logic        m_valid, overflow;
    logic [7:0]  m_data;
    logic [3:0]  m_len;
    logic [15:0] hit_count;
    logic [2:0]  fifo_level;
    logic        m_valid4, overflow4;
    logic [7:0]  m_data4;
    logic [3:0]  m_len4, hit_count4;
    logic [2:0]  fifo_level4;

    int checks = 0;
    int errors = 0;
    int exp_hit = 0;
    int exp_hit4 = 0;

    fsm_window_packer #(.WORD_W(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .win_end(win_end), .z(z), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_len(m_len),
        .hit_count(hit_count), .overflow(overflow), .fifo_level(fifo_level));

    fsm_window_packer #(.WORD_W(8), .FIFO_DEPTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .win_end(win_end), .z(z), .flush(flush),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_len(m_len4),
        .hit_count(hit_count4), .overflow(overflow4), .fifo_level(fifo_level4));

    always #5 clk = ~clk;

    typedef struct {
        logic we, zz, fl, rdy, v;
        logic [7:0]  d;
        logic [3:0]  len;
        logic [2:0]  lvl;
        logic [15:0] hit;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic zz, logic fl, logic rdy, logic v,
                                logic [7:0] d, logic [3:0] len, logic [2:0] lvl, logic [15:0] hit);
        vec_t r;
        r.we = we; r.zz = zz; r.fl = fl; r.rdy = rdy; r.v = v;
        r.d = d; r.len = len; r.lvl = lvl; r.hit = hit;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic zz, input logic fl, input logic rdy);
        win_end = we; z = zz; flush = fl; m_ready = rdy;
        @(posedge clk);
        #1;
        if (we && zz) begin
            exp_hit++;
            if (exp_hit4 < 15) exp_hit4++;
        end
        win_end = 1'b0; z = 1'b0; flush = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy);
        for (int i = 0; i < 8; i++) drive(1'b1, w[i], 1'b0, rdy);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        exp_hit = 0; exp_hit4 = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drain_check(input string name, input logic [7:0] w, input logic [3:0] len);
        chk({name, "_valid"}, 32'(m_valid), 32'd1);
        chk({name, "_data"}, 32'(m_data), 32'(w));
        chk({name, "_len"}, 32'(m_len), 32'(len));
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [7:0] words [5];

    initial begin
        // normal 8-bit word 0x4D, bits 1,0,1,1,0,0,1,0
        tbl.push_back(mk(1,1,0,1, 0,8'h00,0,0,1));
        tbl.push_back(mk(1,0,0,1, 0,8'h00,0,0,1));
        tbl.push_back(mk(1,1,0,1, 0,8'h00,0,0,2));
        tbl.push_back(mk(1,1,0,1, 0,8'h00,0,0,3));
        tbl.push_back(mk(1,0,0,1, 0,8'h00,0,0,3));
        tbl.push_back(mk(1,0,0,1, 0,8'h00,0,0,3));
        tbl.push_back(mk(1,1,0,1, 0,8'h00,0,0,4));
        tbl.push_back(mk(1,0,0,1, 1,8'h4D,8,1,4));
        tbl.push_back(mk(0,0,0,1, 0,8'h00,0,0,4));
        // partial word via flush, then flush on empty packer
        tbl.push_back(mk(1,1,0,1, 0,8'h00,0,0,5));
        tbl.push_back(mk(1,1,0,1, 0,8'h00,0,0,6));
        tbl.push_back(mk(1,0,0,1, 0,8'h00,0,0,6));
        tbl.push_back(mk(0,0,1,1, 1,8'h03,3,1,6));
        tbl.push_back(mk(0,0,1,1, 0,8'h00,0,0,6));
        tbl.push_back(mk(0,0,0,1, 0,8'h00,0,0,6));
        // flush with the completing bit: single full word 0x80
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1,0,0,0, 0,8'h00,0,0,6));
        tbl.push_back(mk(1,1,1,0, 1,8'h80,8,1,7));
        tbl.push_back(mk(0,0,0,0, 1,8'h80,8,1,7));
        tbl.push_back(mk(0,0,0,1, 0,8'h00,0,0,7));

        #1;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_len", 32'(m_len), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_hit", 32'(hit_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].we, tbl[k].zz, tbl[k].fl, tbl[k].rdy);
            chk($sformatf("tbl%0d_valid", k), 32'(m_valid), 32'(tbl[k].v));
            chk($sformatf("tbl%0d_level", k), 32'(fifo_level), 32'(tbl[k].lvl));
            chk($sformatf("tbl%0d_hit", k), 32'(hit_count), 32'(tbl[k].hit));
            chk($sformatf("tbl%0d_ovf", k), 32'(overflow), 0);
            if (tbl[k].v) begin
                chk($sformatf("tbl%0d_data", k), 32'(m_data), 32'(tbl[k].d));
                chk($sformatf("tbl%0d_len", k), 32'(m_len), 32'(tbl[k].len));
            end
        end

        // flush together with a non-completing capture: len includes the new bit
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("fw_level", 32'(fifo_level), 1);
        drain_check("fw", 8'h05, 4'd3);
        chk("fw_hit", 32'(hit_count), 32'(exp_hit));

        // overflow: five words with the consumer stalled
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
        for (int k = 0; k < 4; k++) send_word(words[k], 1'b0);
        chk("ov_level4", 32'(fifo_level), 4);
        chk("ov_ovf_before", 32'(overflow), 0);
        send_word(words[4], 1'b0);
        chk("ov_level_after", 32'(fifo_level), 4);
        chk("ov_ovf_after", 32'(overflow), 1);
        for (int k = 0; k < 4; k++) drain_check($sformatf("ov_w%0d", k), words[k], 4'd8);
        chk("ov_drained", 32'(m_valid), 0);
        chk("ov_sticky", 32'(overflow), 1);
        chk("ov_hit", 32'(hit_count), 32'(exp_hit));

        // async reset mid-word with a queued word
        send_word(8'h0F, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(fifo_level), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(m_valid), 0);
        chk("arst_hit", 32'(hit_count), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_level", 32'(fifo_level), 0);
        exp_hit = 0; exp_hit4 = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_word(8'hA5, 1'b0);
        chk("fresh_level", 32'(fifo_level), 1);
        drain_check("fresh", 8'hA5, 4'd8);
        chk("fresh_hit", 32'(hit_count), 32'(exp_hit));

        // full FIFO, word completes on a dequeue edge
        for (int k = 0; k < 4; k++) send_word(8'(k + 1), 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'(8'h5A >> i), 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk("fd_level", 32'(fifo_level), 4);
        chk("fd_ovf", 32'(overflow), 0);
        drain_check("fd_w1", 8'h02, 4'd8);
        drain_check("fd_w2", 8'h03, 4'd8);
        drain_check("fd_w3", 8'h04, 4'd8);
        drain_check("fd_w4", 8'h5A, 4'd8);
        chk("fd_empty", 32'(fifo_level), 0);

        // z toggling without win_end captures nothing
        for (int i = 0; i < 20; i++) drive(1'b0, 1'(i), 1'b0, 1'b1);
        chk("idle_hit", 32'(hit_count), 32'(exp_hit));
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("idle_flush_level", 32'(fifo_level), 0);
        chk("idle_flush_valid", 32'(m_valid), 0);

        // saturation on the CNT_W=4 instance
        pulse_reset();
        for (int i = 0; i < 14; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("sat_14", 32'(hit_count4), 14);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("sat_15", 32'(hit_count4), 15);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("sat_20", 32'(hit_count4), 32'(exp_hit4));
        chk("sat_hold", 32'(hit_count4), 15);
        chk("wide_20", 32'(hit_count), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
